// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (m0) and loader/debug (m1) share one
// asynchronous-read data RAM through an IDLE/ACCESS/RESP handshake FSM.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   mX_req/we/addr/wdata  (in)     level request held until mX_gnt
//   mX_gnt                (out)    one-cycle accept pulse (IDLE only)
//   mX_rsp_valid/rdata    (out)    response held until mX_rsp_ready
//   mX_rsp_ready          (in)     requester accepts the response
//   mem_we/mem_a/mem_d    (out)    data_ram write enable, address, data
//   mem_spo               (in)     data_ram asynchronous read data
//   busy                  (out)    transaction in flight

module dmem_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rdata,
    input  logic        m0_rsp_ready,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rdata,
    input  logic        m1_rsp_ready,

    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_d,
    input  logic [31:0] mem_spo,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e      state_q;
    logic        last_q;
    logic        owner_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        win_vld;
    logic        win_id;
    logic        owner_rdy;

    // Winner selection: a lone request wins outright; on a tie the port
    // that was not granted last goes first.
    always_comb begin
        win_vld = (state_q == S_IDLE) && (m0_req || m1_req) && !rst;
        if (m0_req && m1_req) begin
            win_id = ~last_q;
        end else begin
            win_id = m1_req;
        end
    end

    assign owner_rdy = owner_q ? m1_rsp_ready : m0_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        state_q <= S_ACCESS;
                        last_q  <= win_id;
                        owner_q <= win_id;
                        we_q    <= win_id ? m1_we    : m0_we;
                        addr_q  <= win_id ? m1_addr  : m0_addr;
                        wdata_q <= win_id ? m1_wdata : m0_wdata;
                    end
                end
                S_ACCESS: begin
                    // Writes return zero so stale read data never leaks.
                    rdata_q <= we_q ? 32'h0 : mem_spo;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (owner_rdy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low combinationally while rst is high so that a
    // reset landing in ACCESS cannot produce a write that same cycle.
    logic in_resp;
    assign in_resp = (state_q == S_RESP) && !rst;

    assign m0_gnt       = win_vld && !win_id;
    assign m1_gnt       = win_vld &&  win_id;

    assign m0_rsp_valid = in_resp && !owner_q;
    assign m1_rsp_valid = in_resp &&  owner_q;
    assign m0_rdata     = m0_rsp_valid ? rdata_q : 32'h0;
    assign m1_rdata     = m1_rsp_valid ? rdata_q : 32'h0;

    assign mem_we       = (state_q == S_ACCESS) && we_q && !rst;
    assign mem_a        = rst ? 32'h0 : addr_q;
    assign mem_d        = rst ? 32'h0 : wdata_q;

    assign busy         = (state_q != S_IDLE) && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m0_rsp_ready = 1;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0, m1_rsp_ready = 1;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rsp_valid, m1_gnt, m1_rsp_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we, busy;
    logic [31:0] mem_a, mem_d, mem_spo;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int we_cnt = 0;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];

    bit gq_port[$];
    int gq_cyc[$];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
        .m0_rsp_ready(m0_rsp_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
        .m1_rsp_ready(m1_rsp_ready),
        .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d),
        .mem_spo(mem_spo), .busy(busy)
    );

    // data_ram: asynchronous read, synchronous write
    assign mem_spo = ram[mem_a[7:0]];
    always @(posedge clk) begin
        if (mem_we) ram[mem_a[7:0]] <= mem_d;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %b want %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: at most one transaction in flight. m_age counts
    // cycles since the grant (1 = memory access, >=2 = response pending).
    bit          m_busy = 0, m_last = 1, m_own = 0, m_we = 0;
    int          m_age = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;

    initial forever begin
        bit any, w;
        @(negedge clk);
        any = m0_req | m1_req;
        w   = (m0_req && m1_req) ? !m_last : m1_req;

        chk1 ("m0_gnt", m0_gnt, !rst && !m_busy && any && !w);
        chk1 ("m1_gnt", m1_gnt, !rst && !m_busy && any &&  w);
        chk1 ("mem_we", mem_we, !rst && m_busy && m_age == 1 && m_we);
        chk32("mem_a", mem_a, rst ? 32'h0 : m_addr);
        chk32("mem_d", mem_d, rst ? 32'h0 : m_wdata);
        chk1 ("busy", busy, !rst && m_busy);
        chk1 ("m0_rsp_valid", m0_rsp_valid,
              !rst && m_busy && m_age >= 2 && !m_own);
        chk1 ("m1_rsp_valid", m1_rsp_valid,
              !rst && m_busy && m_age >= 2 && m_own);
        chk32("m0_rdata", m0_rdata,
              (!rst && m_busy && m_age >= 2 && !m_own) ? m_rdata : 32'h0);
        chk32("m1_rdata", m1_rdata,
              (!rst && m_busy && m_age >= 2 && m_own) ? m_rdata : 32'h0);

        if (m0_gnt === 1'b1) begin gq_port.push_back(0); gq_cyc.push_back(cyc); end
        if (m1_gnt === 1'b1) begin gq_port.push_back(1); gq_cyc.push_back(cyc); end
        if (mem_we === 1'b1) we_cnt++;

        if (rst) begin
            m_busy = 0; m_last = 1; m_own = 0; m_we = 0; m_age = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0;
        end else if (!m_busy) begin
            if (any) begin
                m_busy  = 1;
                m_age   = 1;
                m_last  = w;
                m_own   = w;
                m_we    = w ? m1_we    : m0_we;
                m_addr  = w ? m1_addr  : m0_addr;
                m_wdata = w ? m1_wdata : m0_wdata;
            end
        end else if (m_age == 1) begin
            if (m_we) begin
                ref_mem[m_addr[7:0]] = m_wdata;
                m_rdata = 32'h0;
            end else begin
                m_rdata = ref_mem[m_addr[7:0]];
            end
            m_age = 2;
        end else if (m_own ? m1_rsp_ready : m0_rsp_ready) begin
            m_busy = 0;
        end else begin
            m_age++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic wait_gnt(input bit p);
        int n = 0;
        @(negedge clk);
        while (((p ? m1_gnt : m0_gnt) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("gnt_wait", p ? m1_gnt : m0_gnt, 1'b1);
    endtask

    task automatic txn(input bit p, input bit we, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        int n = 0;
        drive(p, 1, we, a, d);
        wait_gnt(p);
        tick();
        drive(p, 0, we, a, d);
        @(negedge clk);
        while (((p ? m1_rsp_valid : m0_rsp_valid) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("rsp_wait", p ? m1_rsp_valid : m0_rsp_valid, 1'b1);
        rd = p ? m1_rdata : m0_rdata;
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int w0, n;
        bit g0, g1;

        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        ram[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        ram[3] = 32'h33333333; ref_mem[3] = 32'h33333333;

        // Reset state
        tick();
        @(negedge clk);
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_a", mem_a, 32'h0);
        tick();
        rst = 0;

        // Single read of addr 5 by m0
        drive(0, 1, 0, 32'd5, 32'h0);
        m0_rsp_ready = 1;
        @(negedge clk);
        chk1 ("rd_gnt_c0", m0_gnt, 1'b1);
        tick();
        m0_req = 0;
        @(negedge clk);
        chk32("rd_mem_a_c1", mem_a, 32'd5);
        chk1 ("rd_mem_we_c1", mem_we, 1'b0);
        chk1 ("rd_busy_c1", busy, 1'b1);
        tick();
        @(negedge clk);
        chk1 ("rd_valid_c2", m0_rsp_valid, 1'b1);
        chk32("rd_data_c2", m0_rdata, 32'hDEADBEEF);
        tick();

        // Write then read through m1
        w0 = we_cnt;
        txn(1, 1, 32'd9, 32'h12345678, rd);
        chk32("wr_rsp_data", rd, 32'h0);
        chk32("wr_we_pulses", 32'(we_cnt - w0), 32'd1);
        w0 = we_cnt;
        txn(1, 0, 32'd9, 32'h0, rd);
        chk32("rd9_data", rd, 32'h12345678);
        chk32("rd_we_pulses", 32'(we_cnt - w0), 32'd0);

        // Tie and fairness after reset
        do_reset();
        gq_port.delete(); gq_cyc.delete();
        drive(0, 1, 0, 32'd5, 32'h0);
        drive(1, 1, 0, 32'd9, 32'h0);
        n = 0;
        while (gq_port.size() < 4 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        m0_req = 0; m1_req = 0;
        chk32("fair_count", 32'(gq_port.size()), 32'd4);
        if (gq_port.size() >= 4) begin
            chk1("fair_g0", gq_port[0], 1'b0);
            chk1("fair_g1", gq_port[1], 1'b1);
            chk1("fair_g2", gq_port[2], 1'b0);
            chk1("fair_g3", gq_port[3], 1'b1);
            for (int i = 0; i < 3; i++)
                chk32("fair_spacing", 32'(gq_cyc[i+1] - gq_cyc[i]), 32'd3);
        end
        repeat (4) tick();

        // Backpressure on m0 while m1 waits
        m0_rsp_ready = 0;
        drive(0, 1, 0, 32'd5, 32'h0);
        wait_gnt(0);
        tick();
        m0_req = 0;
        drive(1, 1, 0, 32'd9, 32'h0);
        @(negedge clk);
        chk1("bp_m1_gnt_acc", m1_gnt, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1 ("bp_valid", m0_rsp_valid, 1'b1);
            chk32("bp_rdata", m0_rdata, 32'hDEADBEEF);
            chk1 ("bp_m1_gnt", m1_gnt, 1'b0);
            tick();
        end
        m0_rsp_ready = 1;
        @(negedge clk);
        chk1("bp_hs_valid", m0_rsp_valid, 1'b1);
        chk1("bp_hs_m1_gnt", m1_gnt, 1'b0);
        tick();
        @(negedge clk);
        chk1("bp_m1_gnt_after", m1_gnt, 1'b1);
        tick();
        m1_req = 0;
        repeat (4) tick();

        // Reset during ACCESS of an m1 write to addr 3
        drive(1, 1, 1, 32'd3, 32'hBAD0BAD0);
        wait_gnt(1);
        tick();
        rst = 1;
        m1_req = 0;
        @(negedge clk);
        chk1("rstacc_mem_we", mem_we, 1'b0);
        tick();
        rst = 0;
        @(negedge clk);
        chk1 ("rstacc_busy", busy, 1'b0);
        chk32("rstacc_ram3", ram[3], 32'h33333333);
        g1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m1_rsp_valid === 1'b1) g1 = 1;
        end
        chk1("rstacc_no_rsp", g1, 1'b0);
        tick();

        // One-cycle m0 request during m1 RESP is withdrawn
        gq_port.delete(); gq_cyc.delete();
        drive(1, 1, 0, 32'd9, 32'h0);
        wait_gnt(1);
        tick();
        m1_req = 0;
        tick();
        drive(0, 1, 0, 32'd7, 32'h0);
        tick();
        m0_req = 0;
        repeat (5) tick();
        g0 = 0;
        foreach (gq_port[i]) if (gq_port[i] == 0) g0 = 1;
        chk1("wd_no_m0_gnt", g0, 1'b0);

        // Random dual-port traffic, scoreboarded by the model each cycle
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            tick();
            if (g0) m0_req = 0;
            if (g1) m1_req = 0;
            if (!m0_req && $urandom_range(2) == 0)
                drive(0, 1, 1'($urandom_range(1)), 32'($urandom_range(15)),
                      $urandom);
            if (!m1_req && $urandom_range(2) == 0)
                drive(1, 1, 1'($urandom_range(1)), 32'($urandom_range(15)),
                      $urandom);
            m0_rsp_ready = 1'($urandom_range(1));
            m1_rsp_ready = 1'($urandom_range(1));
        end
        m0_req = 0; m1_req = 0;
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        repeat (8) tick();
        for (int a = 0; a < 16; a++)
            chk32("sb_mem", ram[a], ref_mem[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
